// File: rtl/fadd_pipe.sv
// fadd_pipe: three-stage pipelined floating-point adder/subtractor.
// Stage 1 classifies, orders and aligns the operands; stage 2 adds or subtracts
// and normalises; stage 3 rounds to nearest even and packs the result.
// Each stage carries a valid bit, and a stage advances whenever its successor
// can take its contents, which gives full throughput with backpressure.
module fadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  input  logic [3:0]             tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   c,
  output logic [3:0]             out_tag,
  output logic [1:0]             flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SIGW = MAN_W + 4;
  localparam int LZW  = $clog2(SIGW + 1);
  localparam int EW2  = EXP_W + 2;

  localparam logic [SIGW-1:0] SIG_ONES = '1;
  localparam logic [EW2-1:0]  EXP_ALL1 = {2'b00, {EXP_W{1'b1}}};

  // Pipeline control
  logic w_load1;
  logic w_load2;
  logic w_load3;

  logic r1Valid;
  logic r2Valid;
  logic r3Valid;

  // Stage 1 signals
  logic [W-1:0]     w_bEff;
  logic             w_swap;
  logic [W-1:0]     w_x;
  logic [W-1:0]     w_y;
  logic [EXP_W-1:0] w_xExp;
  logic [EXP_W-1:0] w_yExp;
  logic [MAN_W-1:0] w_xMan;
  logic [MAN_W-1:0] w_yMan;
  logic             w_xNan;
  logic             w_yNan;
  logic             w_xInf;
  logic             w_yInf;
  logic             w_xZero;
  logic             w_yZero;
  logic [EXP_W-1:0] w_d;
  logic [SIGW-1:0]  w_sigX;
  logic [SIGW-1:0]  w_sigY;
  logic [SIGW-1:0]  w_alignY;
  logic             w_spec1;
  logic [W-1:0]     w_specRes1;
  logic [1:0]       w_specFlags1;

  logic             r1Sign;
  logic             r1Diff;
  logic [EXP_W-1:0] r1Exp;
  logic [SIGW-1:0]  r1SigX;
  logic [SIGW-1:0]  r1SigY;
  logic [3:0]       r1Tag;
  logic             r1Spec;
  logic [W-1:0]     r1SpecRes;
  logic [1:0]       r1SpecFlags;

  // Stage 2 signals
  logic [SIGW:0]    w_sum;
  logic [SIGW-1:0]  w_diff;
  logic [LZW-1:0]   w_lzc;
  logic             w_found;
  logic [SIGW-1:0]  w_sig2;
  logic [EW2-1:0]   w_exp2;
  logic             w_cancel;
  logic             w_flush;
  logic             w_spec2;
  logic [W-1:0]     w_specRes2;
  logic [1:0]       w_specFlags2;

  logic             r2Sign;
  logic [EW2-1:0]   r2Exp;
  logic [SIGW-1:0]  r2Sig;
  logic [3:0]       r2Tag;
  logic             r2Spec;
  logic [W-1:0]     r2SpecRes;
  logic [1:0]       r2SpecFlags;

  // Stage 3 signals
  logic             w_roundUp;
  logic [MAN_W+1:0] w_rounded;
  logic             w_roundCarry;
  logic [MAN_W-1:0] w_manOut;
  logic [EW2-1:0]   w_exp3;
  logic             w_ovf;
  logic [W-1:0]     w_res3;
  logic [1:0]       w_flags3;

  logic [W-1:0]     r3C;
  logic [3:0]       r3Tag;
  logic [1:0]       r3Flags;

  // A stage loads when it is empty or its successor takes its contents
  assign w_load3  = ~r3Valid | out_ready;
  assign w_load2  = ~r2Valid | w_load3;
  assign w_load1  = ~r1Valid | w_load2;
  assign in_ready = w_load1;

  // Valid bits ripple forward as stages load; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1Valid <= 1'b0;
      r2Valid <= 1'b0;
      r3Valid <= 1'b0;
    end else begin
      if (w_load1) r1Valid <= in_valid;
      if (w_load2) r2Valid <= r1Valid;
      if (w_load3) r3Valid <= r2Valid;
    end
  end

  // ---------------- Stage 1: classify / order / align ----------------
  assign w_bEff = {b[W-1] ^ sub, b[W-2:0]};
  assign w_swap = (a[W-2:0] < w_bEff[W-2:0]);
  assign w_x    = w_swap ? w_bEff : a;
  assign w_y    = w_swap ? a : w_bEff;

  assign w_xExp = w_x[W-2:MAN_W];
  assign w_yExp = w_y[W-2:MAN_W];
  assign w_xMan = w_x[MAN_W-1:0];
  assign w_yMan = w_y[MAN_W-1:0];

  assign w_xNan  = (&w_xExp) & (w_xMan != '0);
  assign w_yNan  = (&w_yExp) & (w_yMan != '0);
  assign w_xInf  = (&w_xExp) & (w_xMan == '0);
  assign w_yInf  = (&w_yExp) & (w_yMan == '0);
  assign w_xZero = (w_xExp == '0);
  assign w_yZero = (w_yExp == '0);

  assign w_d    = w_xExp - w_yExp;
  assign w_sigX = {1'b1, w_xMan, 3'b000};
  assign w_sigY = {1'b1, w_yMan, 3'b000};

  // Align the smaller significand, folding every shifted-out bit into the sticky LSB
  always_comb begin
    w_alignY = '0;
    if (32'(w_d) > SIGW - 1) begin
      w_alignY = {{(SIGW-1){1'b0}}, 1'b1};
    end else begin
      w_alignY = (w_sigY >> w_d)
               | {{(SIGW-1){1'b0}}, |(w_sigY & ~(SIG_ONES << w_d))};
    end
  end

  // Resolve NaN/inf/zero operands up front; the arithmetic path is then ignored
  always_comb begin
    w_spec1      = 1'b0;
    w_specRes1   = '0;
    w_specFlags1 = 2'b00;
    if (w_xNan | w_yNan | (w_xInf & w_yInf & (w_x[W-1] != w_y[W-1]))) begin
      w_spec1      = 1'b1;
      w_specRes1   = {1'b0, {(W-1){1'b1}}};
      w_specFlags1 = 2'b10;
    end else if (w_xInf | w_yInf) begin
      w_spec1    = 1'b1;
      w_specRes1 = w_x;
    end else if (w_xZero & w_yZero) begin
      w_spec1    = 1'b1;
      w_specRes1 = {w_x[W-1] & w_y[W-1], {(W-1){1'b0}}};
    end else if (w_xZero | w_yZero) begin
      w_spec1    = 1'b1;
      w_specRes1 = w_xZero ? w_y : w_x;
    end
  end

  // Stage 1 datapath register; only the valid bit needs a reset
  always_ff @(posedge clk) begin
    if (w_load1 & in_valid) begin
      r1Sign      <= w_x[W-1];
      r1Diff      <= w_x[W-1] ^ w_y[W-1];
      r1Exp       <= w_xExp;
      r1SigX      <= w_sigX;
      r1SigY      <= w_alignY;
      r1Tag       <= tag;
      r1Spec      <= w_spec1;
      r1SpecRes   <= w_specRes1;
      r1SpecFlags <= w_specFlags1;
    end
  end

  // ---------------- Stage 2: add / normalise ----------------
  assign w_sum  = {1'b0, r1SigX} + {1'b0, r1SigY};
  assign w_diff = r1SigX - r1SigY;

  // Leading-zero count of the difference, scanning from the MSB
  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int i = SIGW - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (w_diff[i]) w_found = 1'b1;
        else           w_lzc   = w_lzc + LZW'(1);
      end
    end
  end

  // Same signs add (with carry renormalise); different signs subtract and left-normalise
  always_comb begin
    w_sig2   = r1SigX;
    w_exp2   = EW2'(r1Exp);
    w_cancel = 1'b0;
    if (!r1Diff) begin
      if (w_sum[SIGW]) begin
        w_sig2 = {w_sum[SIGW:2], w_sum[1] | w_sum[0]};
        w_exp2 = EW2'(r1Exp) + EW2'(1);
      end else begin
        w_sig2 = w_sum[SIGW-1:0];
      end
    end else begin
      w_cancel = (w_diff == '0);
      w_sig2   = w_diff << w_lzc;
      w_exp2   = EW2'(r1Exp) - EW2'(w_lzc);
    end
  end

  assign w_flush = w_exp2[EW2-1] | (w_exp2 == '0);

  // Exact cancellation gives +0; an exponent that fell to zero or below flushes to signed zero
  always_comb begin
    w_spec2      = r1Spec;
    w_specRes2   = r1SpecRes;
    w_specFlags2 = r1SpecFlags;
    if (!r1Spec) begin
      if (w_cancel) begin
        w_spec2    = 1'b1;
        w_specRes2 = '0;
      end else if (w_flush) begin
        w_spec2    = 1'b1;
        w_specRes2 = {r1Sign, {(W-1){1'b0}}};
      end
    end
  end

  // Stage 2 datapath register
  always_ff @(posedge clk) begin
    if (w_load2 & r1Valid) begin
      r2Sign      <= r1Sign;
      r2Exp       <= w_exp2;
      r2Sig       <= w_sig2;
      r2Tag       <= r1Tag;
      r2Spec      <= w_spec2;
      r2SpecRes   <= w_specRes2;
      r2SpecFlags <= w_specFlags2;
    end
  end

  // ---------------- Stage 3: round / pack ----------------
  assign w_roundUp    = r2Sig[2] & (r2Sig[1] | r2Sig[0] | r2Sig[3]);
  assign w_rounded    = {1'b0, r2Sig[SIGW-1:3]} + {{(MAN_W+1){1'b0}}, w_roundUp};
  assign w_roundCarry = w_rounded[MAN_W+1];
  assign w_manOut     = w_roundCarry ? w_rounded[MAN_W:1] : w_rounded[MAN_W-1:0];
  assign w_exp3       = r2Exp + EW2'(w_roundCarry);
  assign w_ovf        = (w_exp3 >= EXP_ALL1);

  // Pick special result, overflow to signed infinity, or the packed rounded value
  always_comb begin
    w_res3   = {r2Sign, w_exp3[EXP_W-1:0], w_manOut};
    w_flags3 = 2'b00;
    if (r2Spec) begin
      w_res3   = r2SpecRes;
      w_flags3 = r2SpecFlags;
    end else if (w_ovf) begin
      w_res3   = {r2Sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags3 = 2'b01;
    end
  end

  // Output register: cleared by reset, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3C     <= '0;
      r3Tag   <= '0;
      r3Flags <= '0;
    end else if (w_load3 & r2Valid) begin
      r3C     <= w_res3;
      r3Tag   <= r2Tag;
      r3Flags <= w_flags3;
    end
  end

  assign out_valid = r3Valid;
  assign c         = r3C;
  assign out_tag   = r3Tag;
  assign flags     = r3Flags;

endmodule
